// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package sub_serial_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned slice_count(input int unsigned n);
        return n / SLICE_W;
    endfunction

    // Counter needs at least one bit even for the minimum two-slice width.
    function automatic int unsigned count_width(input int unsigned n);
        int unsigned w;
        w = $clog2(slice_count(n));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sub_serial_slice.sv
// 4-bit subtract-with-borrow cell: D = A - B - BIN, built as A + ~B + ~BIN.
module sub4_slice
    import sub_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               BIN,
    output logic [SLICE_W-1:0] D,
    output logic               BOUT
);

    logic [SLICE_W:0] sum_c;

    always_comb begin
        sum_c = {1'b0, A} + {1'b0, ~B} + {{SLICE_W{1'b0}}, ~BIN};
        D     = sum_c[SLICE_W-1:0];
        BOUT  = ~sum_c[SLICE_W];
    end

endmodule

// File: rtl/sub_serial.sv
// Nibble-serial N-bit subtractor: O = I0 - I1 - CIN over N/4 cycles, valid/ready on both sides.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic         CIN,
    input  logic         I_VALID,
    output logic         I_READY,
    output logic [N-1:0] O,
    output logic         COUT,
    output logic         O_VALID,
    input  logic         O_READY
);

    localparam int unsigned NSLICE = slice_count(N);
    localparam int unsigned KW     = count_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   r_q, r_d;
    logic           borrow_q, borrow_d;
    logic           cout_q, cout_d;

    logic               accept_c;
    logic               last_c;
    logic [SLICE_W-1:0] slice_d_c;
    logic               slice_bout_c;

    assign accept_c = (state_q == ST_IDLE) && I_VALID;
    assign last_c   = (k_q == K_LAST);

    sub4_slice u_slice (
        .A    (a_q[SLICE_W-1:0]),
        .B    (b_q[SLICE_W-1:0]),
        .BIN  (borrow_q),
        .D    (slice_d_c),
        .BOUT (slice_bout_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (I_VALID) state_d = ST_RUN;
            ST_RUN:  if (last_c)  state_d = ST_DONE;
            ST_DONE: if (O_READY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // I_READY is gated by RESET so nothing is accepted while reset is applied.
    always_comb begin
        I_READY = 1'b0;
        O_VALID = 1'b0;
        case (state_q)
            ST_IDLE: I_READY = ~RESET;
            ST_DONE: O_VALID = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        borrow_d = borrow_q;
        cout_d   = cout_q;
        if (accept_c) begin
            a_d      = I0;
            b_d      = I1;
            borrow_d = CIN;
            k_d      = '0;
        end else if (state_q == ST_RUN) begin
            // Result fills from the top so the LSB nibble lands at bit 0 after the last step.
            r_d      = {slice_d_c, r_q[N-1:SLICE_W]};
            a_d      = a_q >> SLICE_W;
            b_d      = b_q >> SLICE_W;
            borrow_d = slice_bout_c;
            k_d      = last_c ? '0 : k_q + KW'(1);
            if (last_c) begin
                cout_d = slice_bout_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            borrow_q <= borrow_d;
            cout_q   <= cout_d;
        end
    end

    assign O    = r_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial at N=16.
module tb_sub_serial;

    localparam int unsigned N = 16;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] I0, I1;
    logic         CIN, I_VALID, I_READY;
    logic [N-1:0] O;
    logic         COUT, O_VALID, O_READY;

    int n_checks = 0;
    int n_errors = 0;

    sub_serial #(.N(N)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I0      (I0),
        .I1      (I1),
        .CIN     (CIN),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .O       (O),
        .COUT    (COUT),
        .O_VALID (O_VALID),
        .O_READY (O_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one operation; returns after the accept edge.
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        check("ready_before_accept", 32'(I_READY), 32'd1);
        I0 = a; I1 = b; CIN = c; I_VALID = 1'b1;
        tick();
        I_VALID = 1'b0;
        I0 = $urandom; I1 = $urandom; CIN = 1'($urandom);
    endtask

    // Waits for O_VALID with a bounded edge count; returns edges taken.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!O_VALID && edges < 20) begin
            tick();
            edges++;
        end
        if (!O_VALID) check("o_valid_timeout", 32'(O_VALID), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c, input logic [N-1:0] exp_o, input logic exp_cout);
        int edges;
        accept(a, b, c);
        wait_valid(edges);
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_o"}, 32'(O), 32'(exp_o));
        check({tag, "_cout"}, 32'(COUT), 32'(exp_cout));
        check({tag, "_iready_in_done"}, 32'(I_READY), 32'd0);
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        check({tag, "_released"}, 32'(O_VALID), 32'd0);
        check({tag, "_o_kept"}, 32'(O), 32'(exp_o));
    endtask

    initial begin
        int edges;
        logic [N-1:0] held_o;
        logic         saw_valid;

        RESET = 1'b1; I0 = '0; I1 = '0; CIN = 1'b0; I_VALID = 1'b0; O_READY = 1'b0;

        tick();
        check("rst_iready", 32'(I_READY), 32'd0);
        tick();
        check("rst_o", 32'(O), 32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
        check("rst_ovalid", 32'(O_VALID), 32'd0);
        check("rst_iready2", 32'(I_READY), 32'd0);
        RESET = 1'b0;
        tick();
        check("post_rst_iready", 32'(I_READY), 32'd1);

        run_op("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
        run_op("under1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_op("under2", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1);
        run_op("ripple1", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
        run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);

        // Backpressure: result must hold while inputs churn.
        accept(16'hA5A5, 16'h1111, 1'b1);
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd4);
        for (int i = 0; i < 6; i++) begin
            I0 = $urandom; I1 = $urandom; CIN = 1'($urandom); I_VALID = 1'($urandom);
            tick();
            check("bp_o", 32'(O), 32'h9493);
            check("bp_cout", 32'(COUT), 32'd0);
            check("bp_ovalid", 32'(O_VALID), 32'd1);
            check("bp_iready", 32'(I_READY), 32'd0);
        end
        I_VALID = 1'b1;
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        I_VALID = 1'b0;
        check("bp_release", 32'(O_VALID), 32'd0);
        check("bp_idle_ready", 32'(I_READY), 32'd1);
        check("bp_o_kept", 32'(O), 32'h9493);
        tick();
        check("bp_no_queue", 32'(O_VALID), 32'd0);

        // Reset two edges into RUN discards the in-flight result.
        accept(16'h1234, 16'h0001, 1'b0);
        tick();
        tick();
        RESET = 1'b1;
        O_READY = 1'b1;
        saw_valid = 1'b0;
        tick();
        check("mid_rst_o", 32'(O), 32'd0);
        check("mid_rst_cout", 32'(COUT), 32'd0);
        check("mid_rst_ovalid", 32'(O_VALID), 32'd0);
        check("mid_rst_iready", 32'(I_READY), 32'd0);
        RESET = 1'b0;
        O_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (O_VALID) saw_valid = 1'b1;
            tick();
        end
        check("mid_rst_no_pulse", 32'(saw_valid), 32'd0);
        check("mid_rst_k", 32'(dut.k_q), 32'd0);
        held_o = O;
        check("mid_rst_o_idle", 32'(held_o), 32'd0);

        run_op("after_rst", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sub_serial.md
# sub_serial

Nibble-serial wide subtractor for area-constrained datapaths. It computes O = I0 − I1 − CIN (mod 2^N) over N/4 clock cycles through one shared 4-bit subtract-with-borrow slice, and reports the final borrow. It sits between a valid/ready producer and a valid/ready consumer, and processes one operation at a time.

## Interface

Parameters:
- N, default 16: operand width; must be a multiple of 4 and at least 8.

Ports:
- CLK, input, 1: the single clock; all state updates on its rising edge.
- RESET, input, 1: synchronous, active-high reset.
- I0, input, N: minuend; sampled only on the accept edge.
- I1, input, N: subtrahend; sampled only on the accept edge.
- CIN, input, 1: borrow-in (1 subtracts one more); sampled on the accept edge.
- I_VALID, input, 1: producer has an operation.
- I_READY, output, 1: block can accept an operation.
- O, output, N: difference; registered.
- COUT, output, 1: borrow-out, 1 iff I0 < I1 + CIN (unsigned); registered.
- O_VALID, output, 1: O and COUT hold a completed result.
- O_READY, input, 1: consumer accepts the result.

## Operation

- FSM states:
  - IDLE: I_READY=1.
  - RUN: processes one nibble per cycle; slice counter k runs from 0 to N/4−1.
  - DONE: O_VALID=1.
- Accept: in IDLE with I_VALID=1, I_READY=1 and RESET=0, the edge does the following.
  - Latches I0 and I1 into operand shift registers.
  - Sets borrow register B to CIN and k to 0.
  - Moves the FSM to RUN.
- RUN, one edge per nibble: the slice computes D = A[3:0] + ~B_op[3:0] + ~B, which is A − B_op − B.
  - The new B is the inverted carry of that sum.
  - D shifts into the top of the result register (LSB nibble first).
  - The operand registers shift right by 4.
  - When k = N/4−1, the FSM goes to DONE and COUT takes the final B.
- DONE: O and COUT stay stable while O_READY=0. On an edge with O_READY=1 the FSM returns to IDLE; O and COUT keep their values.
- Inputs I0, I1 and CIN are don't-care outside the accept edge.
- Borrow propagates across nibbles only through B; no combinational path crosses slices.
- Arithmetic is unsigned and modulo 2^N. Signed overflow is not reported.

## Timing

- Reset state: FSM=IDLE, k=0, B=0, O=0, COUT=0, O_VALID=0.
  - I_READY=0 during any cycle in which RESET=1.
  - I_READY=1 from the first cycle after reset deasserts.
- Latency: O_VALID rises exactly N/4 edges after the accept edge (4 edges for N=16).
- Throughput: one operation per N/4+2 cycles with O_READY held at 1.
  - I_READY is high only in IDLE, so a new operation can't be accepted on the same edge a result is released.
- O_VALID and I_READY are never both 1.
- I_READY depends only on state and RESET; it has no combinational path from I_VALID.
- O_VALID depends only on state.
- RESET mid-RUN or mid-DONE: the next edge restores the reset state, and the in-flight result is discarded with no O_VALID pulse.
- RESET wins over a simultaneous accept or release.
- I_VALID=1 outside IDLE is ignored; no operation is queued.

## Structure

- Shared package holds:
  - the FSM state encoding (IDLE, RUN, DONE);
  - the slice width constant, 4;
  - the derived slice count N/4 and its counter width, clog2(N/4).
- Sub-module sub4_slice is purely combinational.
  - Inputs A[3:0], B[3:0], BIN; outputs D[3:0], BOUT.
  - Implemented as A + ~B + ~BIN, with BOUT the inverted carry-out.
  - This keeps it bit-compatible with the existing 4-bit subtract-with-carry cell.
- Top level holds:
  - the FSM;
  - k;
  - the two operand shift registers;
  - the result shift register;
  - B.

## Test plan

All scenarios use N=16.

- Reset: hold RESET 2 cycles, then release. Require O=0, COUT=0, O_VALID=0, I_READY=0 during RESET, and I_READY=1 afterwards.
- Basic: 0x1234 − 0x0034, CIN=0 → O=0x1200, COUT=0, O_VALID exactly 4 edges after accept.
- Underflow: 0x0000 − 0x0001, CIN=0 → O=0xFFFF, COUT=1. Also 0x0005 − 0x0005, CIN=1 → O=0xFFFF, COUT=1.
- Cross-nibble borrow ripple: 0x8000 − 0x0000, CIN=1 → O=0x7FFF, COUT=0. Also 0xFFFF − 0xFFFF, CIN=0 → O=0x0000, COUT=0.
- Backpressure: hold O_READY=0 for 6 cycles in DONE and change I0, I1, CIN and I_VALID freely. Require O and COUT stable, I_READY=0, and release on the first edge with O_READY=1.
- Reset mid-RUN: assert RESET 2 edges after accept. Require no O_VALID pulse and all registers at reset values. The next operation, 0x00FF − 0x0F00, CIN=0, → O=0xF1FF, COUT=1.
